// File: rtl/regfile_dump_reader_if.sv
// Output stream of the register-file dump reader: one register value per beat.
// A beat transfers on a rising edge where valid and ready are both 1. Once the master
// raises valid, it holds index, data and last stable until that edge. The slave may
// change ready at any time, and ready never feeds back combinationally into the master.
interface regfile_dump_reader_if;
  logic        valid;
  logic        ready;
  logic [4:0]  index;
  logic [31:0] data;
  logic        last;

  modport master (output valid, output index, output data, output last, input ready);
  modport slave  (input valid, input index, input data, input last, output ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Post-halt register-file reader: walks FIRST_REG..LAST_REG through an async read port
// and streams each captured value with its index, a last flag and a running XOR checksum.
module regfile_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic [4:0]                   rf_addr,
  input  logic [31:0]                  rf_data,
  regfile_dump_reader_if.master        dump,
  output logic                         busy,
  output logic                         done,
  output logic [31:0]                  checksum,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  state_t     state;
  logic [4:0] idx;

  // busy is a registered copy of (state is READ or HOLD), so the read address
  // depends only on registered state and idx.
  assign rf_addr   = busy ? idx : 5'd0;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= 5'd0;
      dump.valid <= 1'b0;
      dump.index <= 5'd0;
      dump.data  <= 32'd0;
      dump.last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      checksum   <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_READ;
            idx      <= FIRST_IDX;
            checksum <= 32'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        S_READ: begin
          dump.data  <= rf_data;
          dump.index <= idx;
          dump.last  <= (idx == LAST_IDX);
          dump.valid <= 1'b1;
          state      <= S_HOLD;
        end
        S_HOLD: begin
          // The last word ends the walk, so idx never has to wrap past 31.
          if (dump.ready) begin
            checksum   <= checksum ^ dump.data;
            dump.valid <= 1'b0;
            if (dump.last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 5'd1;
              state <= S_READ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a full-range instance and a 10..12 instance
// share one register-file model; a monitor scores every accepted beat.
module tb_regfile_dump_reader;

  logic        clk;
  logic        reset;
  logic        start_a, start_b;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [31:0] checksum_a, checksum_b;
  logic [1:0]  dbg_state_a, dbg_state_b;
  logic [31:0] rf [32];

  regfile_dump_reader_if a_if ();
  regfile_dump_reader_if b_if ();

  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .rf_addr(rf_addr_a), .rf_data(rf_data_a), .dump(a_if.master),
    .busy(busy_a), .done(done_a), .checksum(checksum_a), .dbg_state(dbg_state_a)
  );

  regfile_dump_reader #(.FIRST_REG(10), .LAST_REG(12)) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .rf_addr(rf_addr_b), .rf_data(rf_data_b), .dump(b_if.master),
    .busy(busy_b), .done(done_b), .checksum(checksum_b), .dbg_state(dbg_state_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_a_q[$];
  logic [63:0] exp_b_q[$];
  logic [31:0] cs_a = 0, cs_b = 0, cs_final_a = 0, cs_final_b = 0;
  int cnt_a = 0, cnt_b = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic last, input logic [4:0] idx, input logic [31:0] d);
    return {26'd0, last, idx, d};
  endfunction

  always @(negedge clk) begin
    if (!reset && a_if.valid && a_if.ready) begin
      if (exp_a_q.size() == 0) check("a_unexpected_beat", exp_a_q.size(), 1);
      else check("a_beat", beat(a_if.last, a_if.index, a_if.data), exp_a_q.pop_front());
      check("a_running_checksum", checksum_a, cs_a);
      cs_a = cs_a ^ a_if.data;
      cnt_a++;
      if (a_if.last) begin cs_final_a = cs_a; cs_a = 0; end
    end
    if (!reset && b_if.valid && b_if.ready) begin
      if (exp_b_q.size() == 0) check("b_unexpected_beat", exp_b_q.size(), 1);
      else check("b_beat", beat(b_if.last, b_if.index, b_if.data), exp_b_q.pop_front());
      check("b_running_checksum", checksum_b, cs_b);
      cs_b = cs_b ^ b_if.data;
      cnt_b++;
      if (b_if.last) begin cs_final_b = cs_b; cs_b = 0; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range_a(input int first, input int last);
    for (int i = first; i <= last; i++)
      exp_a_q.push_back(beat(i == last, 5'(i), 32'h1000 + 32'(i)));
  endtask

  task automatic push_range_b();
    for (int i = 10; i <= 12; i++)
      exp_b_q.push_back(beat(i == 12, 5'(i), 32'h1000 + 32'(i)));
  endtask

  task automatic wait_done(input bit use_b, input string tag);
    int n;
    n = 0;
    while (!(use_b ? done_b : done_a) && n < 300) begin
      tick();
      n++;
    end
    check(tag, use_b ? done_b : done_a, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    a_if.ready = 1'b1;
    b_if.ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
    #1;
    check("rst_valid", a_if.valid, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_checksum", checksum_a, 0);
    check("rst_rf_addr", rf_addr_a, 0);
    check("rst_index", a_if.index, 0);
    check("rst_data", a_if.data, 0);
    check("rst_last", a_if.last, 0);
    check("rst_state", dbg_state_a, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("idle_after_reset", dbg_state_a, 0);

    // Full dump, ready high: first word at E1, DONE reached at E64.
    push_range_a(0, 31);
    cnt_a = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t1_busy_e0", busy_a, 1);
    check("t1_valid_e0", a_if.valid, 0);
    check("t1_state_read", dbg_state_a, 1);
    tick();
    check("t1_valid_e1", a_if.valid, 1);
    check("t1_data_e1", a_if.data, 32'h1000);
    repeat (62) tick();
    check("t1_done_e63", done_a, 0);
    check("t1_last_e63", a_if.last, 1);
    tick();
    check("t1_done_e64", done_a, 1);
    check("t1_busy_e64", busy_a, 0);
    check("t1_rf_addr_done", rf_addr_a, 0);
    check("t1_words", cnt_a, 32);
    check("t1_checksum", checksum_a, 32'h0);
    check("t1_checksum_model", checksum_a, cs_final_a);

    // Backpressure on word 3 while x3 is rewritten.
    push_range_a(0, 31);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (7) tick();
    check("t2_at_word3", a_if.index, 3);
    a_if.ready = 1'b0;
    rf[3] = 32'hDEAD;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_hold_data", a_if.data, 32'h1003);
      check("t2_hold_index", a_if.index, 3);
      check("t2_hold_valid", a_if.valid, 1);
    end
    a_if.ready = 1'b1;
    wait_done(1'b0, "t2_done");
    rf[3] = 32'h1003;

    // start while busy at index 7 is ignored.
    push_range_a(0, 31);
    cnt_a = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!(a_if.valid && a_if.index == 5'd7) && n < 100) begin tick(); n++; end
    check("t3_reach_idx7", a_if.index, 7);
    check("t3_rf_addr_idx7", rf_addr_a, 7);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t3_still_busy", busy_a, 1);
    wait_done(1'b0, "t3_done");
    check("t3_words", cnt_a, 32);

    // Narrow instance: 10..12, then restart from DONE clears the checksum.
    push_range_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_rf_addr_first", rf_addr_b, 10);
    wait_done(1'b1, "b_done");
    check("b_words", cnt_b, 3);
    check("b_checksum", checksum_b, 32'h0000100D);
    push_range_b();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_restart_checksum", checksum_b, 0);
    check("b_restart_done", done_b, 0);
    check("b_restart_busy", busy_b, 1);
    wait_done(1'b1, "b_done2");
    check("b_words2", cnt_b, 6);
    check("b_checksum2", checksum_b, cs_final_b);

    // Reset while holding index 20.
    push_range_a(0, 31);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (!(a_if.valid && a_if.index == 5'd20) && n < 100) begin tick(); n++; end
    a_if.ready = 1'b0;
    check("t4_reach_idx20", a_if.index, 20);
    #3;
    reset = 1'b1;
    #1;
    check("t4_valid_async", a_if.valid, 0);
    check("t4_busy_async", busy_a, 0);
    check("t4_done_async", done_a, 0);
    check("t4_checksum_async", checksum_a, 0);
    exp_a_q.delete();
    cs_a = 0;
    tick();
    tick();
    reset = 1'b0;
    a_if.ready = 1'b1;
    repeat (4) tick();
    check("t4_idle_state", dbg_state_a, 0);
    check("t4_idle_busy", busy_a, 0);
    check("t4_idle_valid", a_if.valid, 0);

    // start held high through completion: one DONE cycle, then a second identical dump.
    push_range_a(0, 31);
    push_range_a(0, 31);
    cnt_a = 0;
    start_a = 1'b1;
    tick();
    wait_done(1'b0, "t5_done1");
    tick();
    check("t5_done_one_cycle", done_a, 0);
    check("t5_restart_busy", busy_a, 1);
    start_a = 1'b0;
    wait_done(1'b0, "t5_done2");
    check("t5_words", cnt_a, 64);

    check("a_queue_empty", exp_a_q.size(), 0);
    check("b_queue_empty", exp_b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
